// File: rtl/smallseg_g0table_updater.sv
// Write-side controller for a small-segment/G0 rule table.
// Turns INSERT/DELETE/MODIFY commands into read-modify-write sequences on
// the table port and keeps the next_index linked chains consistent.
// While a sequence runs it owns the table address and stalls search.
module smallseg_g0table_updater #(
  parameter int TABLE_ENTRY_SIZE = 1738,
  parameter int INDEX_BIT_LEN    = 11,
  parameter int COMMAND_BIT_LEN  = 2,
  parameter int ENTRY_DATA_WIDTH = 171,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [COMMAND_BIT_LEN-1:0]              cmd_op,
  input  logic [INDEX_BIT_LEN-1:0]                cmd_slot,
  input  logic [INDEX_BIT_LEN-1:0]                cmd_pred,
  input  logic [ENTRY_DATA_WIDTH-INDEX_BIT_LEN-1:0] cmd_rule,
  input  logic [INDEX_BIT_LEN-1:0]                search_index_in,
  input  logic [ENTRY_DATA_WIDTH-1:0]             table_entry,
  output logic [INDEX_BIT_LEN-1:0]                tbl_index,
  output logic                                    tbl_we,
  output logic [ENTRY_DATA_WIDTH-1:0]             tbl_din,
  output logic                                    search_stall,
  output logic                                    done,
  output logic                                    err,
  output logic [CNT_WIDTH-1:0]                    upd_count
);

  localparam int RULE_W = ENTRY_DATA_WIDTH - INDEX_BIT_LEN;
  localparam logic [COMMAND_BIT_LEN-1:0] OP_NOP = 2'b00;
  localparam logic [COMMAND_BIT_LEN-1:0] OP_INS = 2'b01;
  localparam logic [COMMAND_BIT_LEN-1:0] OP_DEL = 2'b10;
  localparam logic [INDEX_BIT_LEN-1:0]   MAX_IDX = INDEX_BIT_LEN'(TABLE_ENTRY_SIZE);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_PRED, S_CAP_PRED, S_WR_NEW, S_WR_PRED,
    S_RD_SLOT, S_CAP_SLOT, S_WR_SLOT, S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [INDEX_BIT_LEN-1:0]      addr_q, addr_d;
  logic                          we_q, we_d;
  logic [ENTRY_DATA_WIDTH-1:0]   din_q, din_d;
  logic                          done_q, done_d;
  logic                          err_q, err_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic [COMMAND_BIT_LEN-1:0]    op_q, op_d;
  logic [INDEX_BIT_LEN-1:0]      slot_q, slot_d;
  logic [INDEX_BIT_LEN-1:0]      pred_q, pred_d;
  logic [RULE_W-1:0]             rule_q, rule_d;
  logic [RULE_W-1:0]             pbody_q, pbody_d;  // captured predecessor bits [159:0]
  logic [INDEX_BIT_LEN-1:0]      snext_q, snext_d;  // captured slot next_index
  logic                          bad_cmd;
  logic [INDEX_BIT_LEN-1:0]      ent_next;

  assign ent_next = table_entry[ENTRY_DATA_WIDTH-1:RULE_W];
  assign bad_cmd  = (cmd_slot == '0) || (cmd_slot > MAX_IDX) ||
                    (cmd_pred > MAX_IDX) || (cmd_slot == cmd_pred);

  // Outputs: address muxes to the search pipeline only when idle.
  assign tbl_index    = (state_q == S_IDLE) ? search_index_in : addr_q;
  assign cmd_ready    = (state_q == S_IDLE);
  assign search_stall = (state_q != S_IDLE);
  assign tbl_we       = we_q;
  assign tbl_din      = din_q;
  assign done         = done_q;
  assign err          = err_q;
  assign upd_count    = cnt_q;

  // Next-state logic; write strobes/data are computed one cycle early so
  // they come out of flops while the FSM sits in the matching WR_* state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    din_d   = '0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    slot_d  = slot_q;
    pred_d  = pred_q;
    rule_d  = rule_q;
    pbody_d = pbody_q;
    snext_d = snext_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          slot_d = cmd_slot;
          pred_d = cmd_pred;
          rule_d = cmd_rule;
          err_d  = 1'b0;
          if (cmd_op == OP_NOP) begin
            state_d = S_DONE;
          end else if (bad_cmd) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (cmd_op == OP_INS) begin
            state_d = S_RD_PRED;
            addr_d  = cmd_pred;
          end else begin
            state_d = S_RD_SLOT;
            addr_d  = cmd_slot;
          end
        end
      end
      S_RD_PRED: state_d = S_CAP_PRED;
      S_CAP_PRED: begin
        pbody_d = table_entry[RULE_W-1:0];
        if (op_q == OP_INS) begin
          // New entry inherits the predecessor's old successor.
          state_d = S_WR_NEW;
          we_d    = 1'b1;
          addr_d  = slot_q;
          din_d   = {ent_next, rule_q};
        end else if (ent_next != slot_q) begin
          // Predecessor does not point at the slot: chain is not as claimed.
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = S_WR_PRED;
          we_d    = 1'b1;
          addr_d  = pred_q;
          din_d   = {snext_q, table_entry[RULE_W-1:0]};
        end
      end
      S_WR_NEW: begin
        state_d = S_WR_PRED;
        we_d    = 1'b1;
        addr_d  = pred_q;
        din_d   = {slot_q, pbody_q};
      end
      S_WR_PRED: begin
        if (op_q == OP_DEL) begin
          // Unlinked; now clear the slot.
          state_d = S_WR_SLOT;
          we_d    = 1'b1;
          addr_d  = slot_q;
          din_d   = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RD_SLOT: state_d = S_CAP_SLOT;
      S_CAP_SLOT: begin
        snext_d = ent_next;
        if (op_q == OP_DEL) begin
          state_d = S_RD_PRED;
          addr_d  = pred_q;
        end else begin
          state_d = S_WR_SLOT;
          we_d    = 1'b1;
          addr_d  = slot_q;
          din_d   = {ent_next, rule_q};
        end
      end
      S_WR_SLOT: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    if (state_d == S_DONE && !err_d && op_d != OP_NOP)
      cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
      slot_q  <= '0;
      pred_q  <= '0;
      rule_q  <= '0;
      pbody_q <= '0;
      snext_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      slot_q  <= slot_d;
      pred_q  <= pred_d;
      rule_q  <= rule_d;
      pbody_q <= pbody_d;
      snext_q <= snext_d;
    end
  end

endmodule

// File: doc/smallseg_g0table_updater.md
Name: smallseg_G0table_updater

Overview:
- Write-side controller for one small-segment/G0 rule table. Turns host rule-update commands (insert, delete, modify) into read-modify-write sequences on the table's `we`/`din`/`search_index` port.
- Maintains the singly linked rule chains through the `next_index` field of each entry.
- While an update runs, it owns the table address port and stalls the search pipeline. When idle, it passes search addresses straight through.

Parameters:
- TABLE_ENTRY_SIZE, 1738, highest valid entry index; the table has TABLE_ENTRY_SIZE+1 entries.
- INDEX_BIT_LEN, 11, width of entry index, ruleID and next_index.
- COMMAND_BIT_LEN, 2, width of the command opcode.
- ENTRY_DATA_WIDTH, 171, table entry width.
- CNT_WIDTH, 16, width of the completed-update counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready.
- cmd_op  in  COMMAND_BIT_LEN  00 NOP, 01 INSERT, 10 DELETE, 11 MODIFY.
- cmd_slot  in  INDEX_BIT_LEN  target entry index.
- cmd_pred  in  INDEX_BIT_LEN  chain predecessor of the slot (INSERT/DELETE).
- cmd_rule  in  ENTRY_DATA_WIDTH-11  new entry bits [159:0]: ruleID and match fields.
- search_index_in  in  INDEX_BIT_LEN  address from the search pipeline.
- table_entry  in  ENTRY_DATA_WIDTH  table read data, valid the cycle after tbl_index is presented.
- tbl_index  out  INDEX_BIT_LEN  table address.
- tbl_we  out  1  table write enable.
- tbl_din  out  ENTRY_DATA_WIDTH  table write data.
- search_stall  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  valid with done; 1 means the command was rejected and nothing was written.
- upd_count  out  CNT_WIDTH  number of successfully completed INSERT/DELETE/MODIFY commands.

Behaviour:
- Entry layout:
  - [170:160] next_index
  - [159:149] ruleID
  - [148] protocol wildcard
  - [147:140] protocol
  - [139:124] dstPort low, [123:108] dstPort high
  - [107:92] srcPort low, [91:76] srcPort high
  - [75:70] dstIP prefix length, [69:38] dstIP
  - [37:32] srcIP prefix length, [31:0] srcIP
- Index 0 is the chain-head sentinel. It is never a legal cmd_slot.
- Reset (async, rst_n=0):
  - FSM returns to IDLE.
  - tbl_we=0, done=0, err=0, upd_count=0, search_stall=0, all capture registers cleared.
  - A sequence in progress is abandoned; writes already issued remain in the table.
- tbl_index = search_index_in (combinational) in IDLE, otherwise the FSM address register.
- tbl_we, tbl_din and the FSM address are registered. tbl_we=0 in every state except WR_*.
- Validation happens at acceptance (cycle T). The following go to DONE at T+1 with err=1 and no writes:
  - cmd_slot==0 or cmd_slot>TABLE_ENTRY_SIZE;
  - cmd_pred>TABLE_ENTRY_SIZE;
  - cmd_slot==cmd_pred.
- NOP: DONE at T+1 with err=0; upd_count unchanged.
- INSERT (pred -> slot -> old pred.next):
  - T+1 RD_PRED (index=pred)
  - T+2 CAP_PRED (latch table_entry)
  - T+3 WR_NEW: we=1, index=slot, din={pred.next, cmd_rule}
  - T+4 WR_PRED: we=1, index=pred, din={slot, pred[159:0]}
  - T+5 DONE
- DELETE:
  - T+1 RD_SLOT, T+2 CAP_SLOT
  - T+3 RD_PRED, T+4 CAP_PRED
  - If captured pred.next != slot: DONE at T+5 with err=1, no writes.
  - Otherwise: T+5 WR_PRED (din={slot.next, pred[159:0]}), T+6 WR_SLOT (din=0), T+7 DONE.
- MODIFY:
  - T+1 RD_SLOT, T+2 CAP_SLOT
  - T+3 WR_SLOT: din={slot.next, cmd_rule}
  - T+4 DONE
- DONE state:
  - done=1 for exactly one cycle; err as determined above.
  - upd_count increments if err=0 and the op is not NOP; it wraps at 2^CNT_WIDTH.
  - Next cycle: IDLE, cmd_ready=1.
- Command inputs are latched at acceptance. Changes to them during a sequence have no effect.
- cmd_valid while busy is ignored; the host holds it until cmd_ready.
- cmd_ready=0 in every state except IDLE. Back-to-back commands: the next accept is possible the cycle after DONE.

Test Plan:
- Reset mid-INSERT: assert rst_n=0 at T+3 -> tbl_we drops to 0 immediately, then cmd_ready=1, upd_count=0, search_stall=0 after release.
- INSERT slot=5, pred=0, table[0].next=12 -> T+3 writes table[5]={12,rule}, T+4 writes table[0].next=5, done at T+5 with err=0, upd_count=1.
- DELETE slot=5, pred=0 after the insert -> table[0].next=12, table[5]=0, done at T+7, upd_count=2.
- DELETE slot=7, pred=0 with table[0].next=12 -> err=1 at T+5, tbl_we never asserted, upd_count unchanged.
- MODIFY slot=12 with new ruleID 0x2A -> table[12][159:149]=0x2A, next_index preserved, done at T+4.
- Illegal commands: slot=0, slot=1739, slot==pred=9 -> each gives done+err at T+1 with no writes. In IDLE, tbl_index follows search_index_in the same cycle (e.g. 100 -> 100).
